// File: rtl/pkt_dma_pkg.sv
// Shared types and helpers for the packet DMA read/write controllers.
package pkt_dma_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StData = 2'd2,
    StDone = 2'd3
  } pkt_state_e;

  localparam int unsigned WORD_BYTES = 4;

  // Size of the next burst: whatever is left, capped at the configured maximum.
  function automatic logic [29:0] min_burst(input logic [29:0] remaining,
                                            input logic [29:0] max_burst);
    return (remaining < max_burst) ? remaining : max_burst;
  endfunction

endpackage

// File: rtl/pkt_burst_calc.sv
// Tracks the word address and word count still to fetch, and sizes the next burst.
module pkt_burst_calc
  import pkt_dma_pkg::*;
#(
  parameter int unsigned MaxBurst = 64,
  parameter int unsigned BurstW   = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic [29:0]       base_word_i,
  input  logic [29:0]       len_i,
  input  logic              advance_i,
  output logic [31:0]       base_addr_o,
  output logic [29:0]       remaining_o,
  output logic [BurstW-1:0] burst_len_o,
  output logic              last_burst_o
);

  logic [29:0] base_q, base_d;
  logic [29:0] remaining_q, remaining_d;
  logic [29:0] burst_full;

  assign burst_full   = min_burst(remaining_q, 30'(MaxBurst));
  assign burst_len_o  = BurstW'(burst_full);
  assign last_burst_o = (remaining_q == burst_full);
  assign remaining_o  = remaining_q;
  // Word-address arithmetic wraps at 2^30 words, i.e. modulo 2^32 bytes.
  assign base_addr_o  = 32'(base_q) * 32'(WORD_BYTES);

  // Load on start, step past the finished burst on its last beat.
  always_comb begin
    base_d      = base_q;
    remaining_d = remaining_q;
    if (load_i) begin
      base_d      = base_word_i;
      remaining_d = len_i;
    end else if (advance_i) begin
      base_d      = base_q + burst_full;
      remaining_d = remaining_q - burst_full;
    end
  end

  // Counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      base_q      <= '0;
      remaining_q <= '0;
    end else begin
      base_q      <= base_d;
      remaining_q <= remaining_d;
    end
  end

endmodule

// File: rtl/pkt_rd_ctrl.sv
// Avalon-MM burst-read master moving a captured packet from memory into the packet FIFO.
module pkt_rd_ctrl
  import pkt_dma_pkg::*;
#(
  parameter int unsigned MaxBurst = 64,
  parameter int unsigned BurstW   = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              rd_ctrl_i,
  output logic              rd_ctrl_rdy_o,
  output logic              busy_o,
  input  logic [31:0]       pkt_begin_i,
  input  logic [31:0]       pkt_end_i,
  input  logic              almost_full_i,
  output logic [31:0]       fifo_in_o,
  output logic              wr_to_fifo_o,
  output logic [31:0]       address_o,
  output logic              read_o,
  output logic [BurstW-1:0] burstcount_o,
  input  logic              waitrequest_i,
  input  logic [31:0]       readdata_i,
  input  logic              readdatavalid_i
);

  pkt_state_e        state_q, state_d;
  logic              read_q, read_d;
  logic [31:0]       address_q, address_d;
  logic [BurstW-1:0] burstcount_q, burstcount_d;
  logic [BurstW-1:0] beats_q, beats_d;
  logic [31:0]       fifo_in_q, fifo_in_d;
  logic              wr_q, wr_d;
  logic              rdy_q, rdy_d;
  logic              busy_q, busy_d;

  logic [29:0]       begin_word, end_word, start_len;
  logic              start_empty;
  logic              load, advance;
  logic [31:0]       base_addr;
  logic [29:0]       remaining;
  logic [BurstW-1:0] burst_len;
  logic              last_burst;
  logic              unused_lsbs;

  assign begin_word  = pkt_begin_i[31:2];
  assign end_word    = pkt_end_i[31:2];
  assign start_len   = end_word - begin_word;
  assign start_empty = (end_word <= begin_word);
  assign unused_lsbs = ^{pkt_begin_i[1:0], pkt_end_i[1:0], remaining};

  pkt_burst_calc #(
    .MaxBurst(MaxBurst),
    .BurstW  (BurstW)
  ) u_burst_calc (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .load_i      (load),
    .base_word_i (begin_word),
    .len_i       (start_len),
    .advance_i   (advance),
    .base_addr_o (base_addr),
    .remaining_o (remaining),
    .burst_len_o (burst_len),
    .last_burst_o(last_burst)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    read_d       = read_q;
    address_d    = address_q;
    burstcount_d = burstcount_q;
    beats_d      = beats_q;
    fifo_in_d    = fifo_in_q;
    wr_d         = 1'b0;
    load         = 1'b0;
    advance      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (rd_ctrl_i) begin
          if (start_empty) begin
            state_d = StDone;
          end else begin
            load    = 1'b1;
            state_d = StReq;
            // Issue straight away so read rises the cycle after the start.
            if (!almost_full_i) begin
              read_d       = 1'b1;
              address_d    = {begin_word, 2'b00};
              burstcount_d = BurstW'(min_burst(start_len, 30'(MaxBurst)));
            end
          end
        end
      end
      StReq: begin
        if (read_q) begin
          if (!waitrequest_i) begin
            read_d  = 1'b0;
            beats_d = burstcount_q;
            state_d = StData;
          end
        end else if (!almost_full_i) begin
          read_d       = 1'b1;
          address_d    = base_addr;
          burstcount_d = burst_len;
        end
      end
      StData: begin
        // FIFO space was reserved when the burst was issued.
        if (readdatavalid_i) begin
          fifo_in_d = readdata_i;
          wr_d      = 1'b1;
          beats_d   = beats_q - BurstW'(1);
          if (beats_q == BurstW'(1)) begin
            advance = 1'b1;
            state_d = last_burst ? StDone : StReq;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    rdy_d  = (state_d == StDone);
    busy_d = (state_d != StIdle);
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      read_q       <= 1'b0;
      address_q    <= '0;
      burstcount_q <= '0;
      beats_q      <= '0;
      fifo_in_q    <= '0;
      wr_q         <= 1'b0;
      rdy_q        <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      read_q       <= read_d;
      address_q    <= address_d;
      burstcount_q <= burstcount_d;
      beats_q      <= beats_d;
      fifo_in_q    <= fifo_in_d;
      wr_q         <= wr_d;
      rdy_q        <= rdy_d;
      busy_q       <= busy_d;
    end
  end

  assign read_o        = read_q;
  assign address_o     = address_q;
  assign burstcount_o  = burstcount_q;
  assign fifo_in_o     = fifo_in_q;
  assign wr_to_fifo_o  = wr_q;
  assign rd_ctrl_rdy_o = rdy_q;
  assign busy_o        = busy_q;

endmodule

// File: tb/tb_pkt_rd_ctrl.sv
// Directed bench for pkt_rd_ctrl with a simple Avalon slave and FIFO-side monitor.
module tb_pkt_rd_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd_ctrl;
  logic        rd_ctrl_rdy;
  logic        busy;
  logic [31:0] pkt_begin;
  logic [31:0] pkt_end;
  logic        almost_full;
  logic [31:0] fifo_in;
  logic        wr_to_fifo;
  logic [31:0] address;
  logic        read;
  logic [15:0] burstcount;
  logic        waitrequest;
  logic [31:0] readdata;
  logic        readdatavalid;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pkt_rd_ctrl #(
    .MaxBurst(64),
    .BurstW  (16)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .rd_ctrl_i      (rd_ctrl),
    .rd_ctrl_rdy_o  (rd_ctrl_rdy),
    .busy_o         (busy),
    .pkt_begin_i    (pkt_begin),
    .pkt_end_i      (pkt_end),
    .almost_full_i  (almost_full),
    .fifo_in_o      (fifo_in),
    .wr_to_fifo_o   (wr_to_fifo),
    .address_o      (address),
    .read_o         (read),
    .burstcount_o   (burstcount),
    .waitrequest_i  (waitrequest),
    .readdata_i     (readdata),
    .readdatavalid_i(readdatavalid)
  );

  // Monitor logs
  logic [31:0] fifo_log[$];
  logic [31:0] cmd_addr[$];
  logic [15:0] cmd_bc[$];
  int          rdy_cnt, read_cyc, stab_err, cyc, rdy_cyc, last_wr_cyc;
  logic        prev_hold = 1'b0;
  logic [31:0] prev_addr;
  logic [15:0] prev_bc;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hold = 1'b0;
    end else begin
      if (wr_to_fifo) begin
        fifo_log.push_back(fifo_in);
        last_wr_cyc = cyc;
      end
      if (rd_ctrl_rdy) begin
        rdy_cnt++;
        rdy_cyc = cyc;
      end
      if (read) read_cyc++;
      if (read && !waitrequest) begin
        cmd_addr.push_back(address);
        cmd_bc.push_back(burstcount);
      end
      if (prev_hold && (!read || address !== prev_addr || burstcount !== prev_bc)) stab_err++;
      prev_hold = read && waitrequest;
      prev_addr = address;
      prev_bc   = burstcount;
    end
  end

  // Avalon slave: optional waitrequest stall, then one beat per cycle; data = 0xD0000000 + word addr
  int          stall_cfg  = 0;
  int          stall_left = 0;
  logic [31:0] s_addr;
  int          s_n;

  initial begin
    waitrequest   = 1'b1;
    readdatavalid = 1'b0;
    readdata      = '0;
    forever begin
      @(posedge clk); #1;
      if (read) begin
        if (stall_left > 0) begin
          waitrequest = 1'b1;
          stall_left--;
        end else begin
          waitrequest = 1'b0;
          s_addr      = address;
          s_n         = int'(burstcount);
          @(posedge clk); #1;
          waitrequest = 1'b1;
          for (int i = 0; i < s_n; i++) begin
            readdatavalid = 1'b1;
            readdata      = 32'hD000_0000 + (s_addr >> 2) + 32'(i);
            @(posedge clk); #1;
          end
          readdatavalid = 1'b0;
          readdata      = '0;
          stall_left    = stall_cfg;
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic clear_logs();
    fifo_log.delete();
    cmd_addr.delete();
    cmd_bc.delete();
    rdy_cnt  = 0;
    read_cyc = 0;
    stab_err = 0;
  endtask

  task automatic start(input logic [31:0] b, input logic [31:0] e);
    pkt_begin = b;
    pkt_end   = e;
    rd_ctrl   = 1'b1;
    @(posedge clk); #1;
    rd_ctrl = 1'b0;
  endtask

  task automatic wait_rdy(input int budget);
    int k = 0;
    while (rdy_cnt == 0 && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rd_ctrl = 1'b0; pkt_begin = '0; pkt_end = '0; almost_full = 1'b0;
    step(3);
    n_tests++;
    if ({read, wr_to_fifo, rd_ctrl_rdy, busy} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 0000", {read, wr_to_fifo, rd_ctrl_rdy, busy});
    end
    n_tests++;
    if (address !== 32'h0) begin
      n_fail++; $display("FAIL reset_address: got %h want 0", address);
    end
    n_tests++;
    if (burstcount !== 16'h0) begin
      n_fail++; $display("FAIL reset_burstcount: got %h want 0", burstcount);
    end
    n_tests++;
    if (fifo_in !== 32'h0) begin
      n_fail++; $display("FAIL reset_fifo_in: got %h want 0", fifo_in);
    end
    @(negedge clk) rst_n = 1'b1;
    step(2);
    n_tests++;
    if ({read, busy} !== 2'b00) begin
      n_fail++; $display("FAIL idle_after_reset: got %b want 00", {read, busy});
    end
  endtask

  task automatic test_single_burst();
    clear_logs();
    start(32'h1000, 32'h1010);
    n_tests++;
    if ({read, busy, address, burstcount} !== {1'b1, 1'b1, 32'h1000, 16'd4}) begin
      n_fail++;
      $display("FAIL single_issue: got rd=%b busy=%b addr=%h bc=%0d want 1 1 1000 4",
               read, busy, address, burstcount);
    end
    wait_rdy(200);
    step(3);
    n_tests++;
    if (rdy_cnt != 1) begin
      n_fail++; $display("FAIL single_rdy_count: got %0d want 1", rdy_cnt);
    end
    n_tests++;
    if (rdy_cyc != last_wr_cyc) begin
      n_fail++; $display("FAIL single_rdy_timing: got cyc %0d want %0d", rdy_cyc, last_wr_cyc);
    end
    n_tests++;
    if (fifo_log.size() != 4) begin
      n_fail++; $display("FAIL single_wr_count: got %0d want 4", fifo_log.size());
    end
    for (int i = 0; i < 4; i++) begin
      logic [31:0] obs;
      obs = (i < fifo_log.size()) ? fifo_log[i] : 32'hxxxx_xxxx;
      n_tests++;
      if (obs !== 32'hD000_0400 + 32'(i)) begin
        n_fail++; $display("FAIL single_data[%0d]: got %h want %h", i, obs, 32'hD000_0400 + 32'(i));
      end
    end
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL single_busy_end: got %b want 0", busy);
    end
  endtask

  task automatic test_unaligned();
    clear_logs();
    start(32'h5002, 32'h5007);
    wait_rdy(100);
    step(2);
    n_tests++;
    if (cmd_addr.size() != 1 || cmd_addr[0] !== 32'h5000 || cmd_bc[0] !== 16'd1) begin
      n_fail++; $display("FAIL unaligned_cmd: got %0d cmds, want one at 5000 bc=1", cmd_addr.size());
    end
    n_tests++;
    if (fifo_log.size() != 1 || fifo_log[0] !== 32'hD000_1400) begin
      n_fail++; $display("FAIL unaligned_data: got %0d writes, want one of d0001400", fifo_log.size());
    end
  endtask

  task automatic test_multi_burst();
    logic [31:0] exp_a[3];
    logic [15:0] exp_b[3];
    exp_a = '{32'h2000, 32'h2100, 32'h2200};
    exp_b = '{16'd64, 16'd64, 16'd22};
    clear_logs();
    start(32'h2000, 32'h2000 + 32'd600);
    pkt_begin = 32'hDEAD_0000;  // changes after latching must not matter
    pkt_end   = 32'h0000_0010;
    wait_rdy(1000);
    step(2);
    n_tests++;
    if (cmd_addr.size() != 3) begin
      n_fail++; $display("FAIL multi_cmd_count: got %0d want 3", cmd_addr.size());
    end
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (i >= cmd_addr.size() || cmd_addr[i] !== exp_a[i] || cmd_bc[i] !== exp_b[i]) begin
        n_fail++;
        $display("FAIL multi_cmd[%0d]: got %h/%0d want %h/%0d", i,
                 (i < cmd_addr.size()) ? cmd_addr[i] : 32'hx,
                 (i < cmd_bc.size()) ? cmd_bc[i] : 16'hx, exp_a[i], exp_b[i]);
      end
    end
    n_tests++;
    if (fifo_log.size() != 150) begin
      n_fail++; $display("FAIL multi_wr_count: got %0d want 150", fifo_log.size());
    end
    for (int i = 0; i < 150; i++) begin
      logic [31:0] obs;
      obs = (i < fifo_log.size()) ? fifo_log[i] : 32'hxxxx_xxxx;
      n_tests++;
      if (obs !== 32'hD000_0800 + 32'(i)) begin
        n_fail++; $display("FAIL multi_data[%0d]: got %h want %h", i, obs, 32'hD000_0800 + 32'(i));
      end
    end
    n_tests++;
    if (rdy_cnt != 1) begin
      n_fail++; $display("FAIL multi_rdy_count: got %0d want 1", rdy_cnt);
    end
  endtask

  task automatic test_stalls();
    int bad = 0;
    int k   = 0;
    clear_logs();
    stall_cfg   = 5;
    stall_left  = 5;
    almost_full = 1'b1;
    start(32'h4000, 32'h4020);
    for (int i = 0; i < 10; i++) begin
      if (read !== 1'b0) bad++;
      step(1);
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++; $display("FAIL stall_read_while_full: got %0d cycles with read, want 0", bad);
    end
    almost_full = 1'b0;
    while (cmd_addr.size() == 0 && k < 50) begin
      step(1);
      k++;
    end
    almost_full = 1'b1;  // must be ignored once the burst is accepted
    wait_rdy(100);
    step(2);
    almost_full = 1'b0;
    stall_cfg   = 0;
    stall_left  = 0;
    n_tests++;
    if (cmd_addr.size() != 1 || cmd_addr[0] !== 32'h4000 || cmd_bc[0] !== 16'd8) begin
      n_fail++; $display("FAIL stall_cmd: got %0d cmds, want one at 4000 bc=8", cmd_addr.size());
    end
    n_tests++;
    if (read_cyc != 6) begin
      n_fail++; $display("FAIL stall_read_cycles: got %0d want 6", read_cyc);
    end
    n_tests++;
    if (stab_err != 0) begin
      n_fail++; $display("FAIL stall_cmd_stable: got %0d changes want 0", stab_err);
    end
    n_tests++;
    if (fifo_log.size() != 8) begin
      n_fail++; $display("FAIL stall_wr_count: got %0d want 8", fifo_log.size());
    end
  endtask

  task automatic test_empty();
    logic [31:0] bs[3];
    logic [31:0] es[3];
    bs = '{32'h3000, 32'h3000, 32'hFFFF_FFF8};
    es = '{32'h3000, 32'h2FF0, 32'h0000_0008};
    clear_logs();
    for (int i = 0; i < 3; i++) begin
      start(bs[i], es[i]);
      n_tests++;
      if ({rd_ctrl_rdy, read, busy} !== 3'b101) begin
        n_fail++; $display("FAIL empty_rdy[%0d]: got rdy/rd/busy=%b want 101", i,
                           {rd_ctrl_rdy, read, busy});
      end
      step(1);
      n_tests++;
      if ({rd_ctrl_rdy, busy} !== 2'b00) begin
        n_fail++; $display("FAIL empty_back_idle[%0d]: got %b want 00", i, {rd_ctrl_rdy, busy});
      end
    end
    step(3);
    n_tests++;
    if (read_cyc != 0 || cmd_addr.size() != 0) begin
      n_fail++; $display("FAIL empty_no_read: got %0d read cycles want 0", read_cyc);
    end
    n_tests++;
    if (rdy_cnt != 3) begin
      n_fail++; $display("FAIL empty_rdy_count: got %0d want 3", rdy_cnt);
    end
  endtask

  task automatic test_reset_mid_burst();
    int k = 0;
    clear_logs();
    start(32'h6000, 32'h6020);
    while (fifo_log.size() < 1 && k < 50) begin
      step(1);
      k++;
    end
    pkt_begin = 32'h7000;
    pkt_end   = 32'h7010;
    rd_ctrl   = 1'b1;
    step(1);
    rd_ctrl = 1'b0;
    while (fifo_log.size() < 2 && k < 100) begin
      step(1);
      k++;
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({read, wr_to_fifo, rd_ctrl_rdy, busy, address, burstcount, fifo_in} !== '0) begin
      n_fail++;
      $display("FAIL midreset_clear: got rd=%b wr=%b rdy=%b busy=%b addr=%h bc=%0d fi=%h want all 0",
               read, wr_to_fifo, rd_ctrl_rdy, busy, address, burstcount, fifo_in);
    end
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;
    step(12);
    n_tests++;
    if (fifo_log.size() != 2) begin
      n_fail++; $display("FAIL midreset_writes: got %0d want 2", fifo_log.size());
    end
    n_tests++;
    if (cmd_addr.size() != 1 || cmd_addr[0] !== 32'h6000 || rdy_cnt != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_ignored_start: got %0d cmds rdy=%0d busy=%b want 1 0 0",
               cmd_addr.size(), rdy_cnt, busy);
    end
    clear_logs();
    start(32'h1000, 32'h1010);
    wait_rdy(100);
    step(2);
    n_tests++;
    if (cmd_addr.size() != 1 || cmd_addr[0] !== 32'h1000 || cmd_bc[0] !== 16'd4) begin
      n_fail++; $display("FAIL midreset_restart_cmd: got %0d cmds want one at 1000 bc=4",
                         cmd_addr.size());
    end
    for (int i = 0; i < 4; i++) begin
      logic [31:0] obs;
      obs = (i < fifo_log.size()) ? fifo_log[i] : 32'hxxxx_xxxx;
      n_tests++;
      if (obs !== 32'hD000_0400 + 32'(i)) begin
        n_fail++;
        $display("FAIL midreset_restart_data[%0d]: got %h want %h", i, obs, 32'hD000_0400 + 32'(i));
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_unaligned();
    test_multi_burst();
    test_stalls();
    test_empty();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pkt_rd_ctrl.md
# pkt_rd_ctrl

Avalon-MM burst-read master that fetches a captured packet from memory, byte range [pkt_begin, pkt_end), and pushes it word-by-word into the outbound packet FIFO. It is the read-side counterpart of the capture write controller and shares its start/ready handshake style and packet-address registers. Transfers are split into bursts of at most MAX_BURST words. A burst is issued only when the FIFO can absorb it.

## Interface
- MAX_BURST, 64: maximum words per Avalon burst, 1..65535.
- BURST_W, 16: width of burstcount.
- clk  in  1  sole clock.
- reset  in  1  asynchronous, active-low reset.
- rd_ctrl  in  1  start request, sampled in IDLE only.
- rd_ctrl_rdy  out  1  one-cycle pulse when the packet has been fully pushed (or rejected as empty).
- busy  out  1  high in any state other than IDLE.
- pkt_begin  in  32  first byte address; bits [1:0] ignored.
- pkt_end  in  32  byte address one past the last byte; bits [1:0] ignored.
- almost_full  in  1  FIFO has fewer than MAX_BURST free entries.
- fifo_in  out  32  data to FIFO.
- wr_to_fifo  out  1  FIFO write strobe.
- address  out  32  Avalon byte address.
- read  out  1  Avalon read request.
- burstcount  out  BURST_W  Avalon burst length in words.
- waitrequest  in  1  Avalon slave stall.
- readdata  in  32  Avalon read data.
- readdatavalid  in  1  Avalon read data qualifier.

## Operation
- States: IDLE, REQ, DATA, DONE.
- **IDLE**
  - On rd_ctrl=1: latch base={pkt_begin[31:2],2'b00} and remaining=(pkt_end[31:2]-pkt_begin[31:2]) as a 30-bit count.
  - If pkt_end[31:2] <= pkt_begin[31:2] (unsigned): go to DONE and issue no read.
  - Otherwise go to REQ.
- **REQ**
  - Wait while almost_full=1, with read=0.
  - When almost_full=0: drive read=1, address=base, burstcount=min(remaining, MAX_BURST).
  - Hold all three stable until sampled with waitrequest=0, then go to DATA with beat counter = burstcount.
- **DATA**
  - Each readdatavalid=1 cycle: register readdata into fifo_in, pulse wr_to_fifo next cycle, decrement the beat counter.
  - almost_full is ignored here; the credit was reserved at issue.
  - On the last beat: base += burstcount*4 (mod 2^32) and remaining -= burstcount. Go to REQ if remaining != 0, else go to DONE.
- **DONE**
  - rd_ctrl_rdy=1 for exactly one cycle, then go to IDLE.
- Only one burst is outstanding at a time; no pipelined bursts.
- rd_ctrl outside IDLE is ignored. pkt_begin/pkt_end changes after latching have no effect.
- readdatavalid outside DATA is ignored; nothing is written to the FIFO.
- Address wraps modulo 2^32 when base + length crosses 0xFFFF_FFFC.

## Timing
- All outputs are registered.
- Reset values: state=IDLE, read=0, address=0, burstcount=0, wr_to_fifo=0, fifo_in=0, rd_ctrl_rdy=0, busy=0.
- Start latency: rd_ctrl sampled at edge N gives read=1 at edge N+1 (REQ entered at N+1, almost_full=0).
- Data latency: readdatavalid sampled at edge M gives wr_to_fifo=1 and fifo_in=readdata during cycle M+1.
- Completion: last data beat at edge M gives wr_to_fifo=1 at M+1 and rd_ctrl_rdy=1 at M+1 (DONE). IDLE at M+2; a new start is accepted from M+2.
- Empty packet: rd_ctrl at N gives rd_ctrl_rdy=1 at N+1.
- Reset asserted mid-transfer clears everything asynchronously. Beats arriving afterwards are dropped because state is IDLE.

## Structure
- Package pkt_dma_pkg holds:
  - the state enum, shared in style with the write controller;
  - WORD_BYTES=4;
  - a min-burst function.
- One sub-module is natural: pkt_burst_calc, holding the remaining/base counters and the next-burst size.

## Test plan
- Begin=0x1000, end=0x1010, MAX_BURST=64, no stalls -> one burst: address=0x1000, burstcount=4. Four FIFO writes D0..D3 in order, then one rd_ctrl_rdy pulse.
- Begin=0x2000, end=0x2000+4*150, MAX_BURST=64 -> three bursts with burstcount 64, 64, 22 at 0x2000, 0x2100, 0x2200. 150 FIFO writes.
- waitrequest held 5 cycles and almost_full=1 for 10 cycles before issue -> read stays 0 while almost_full=1. Address and burstcount stay stable through waitrequest. Exactly one command is accepted.
- Begin=0x3000, end=0x3000, then end<begin -> no read asserted; rd_ctrl_rdy one cycle after start.
- Begin=0xFFFF_FFF8, end=0x0000_0008 -> address wraps. Treated as end<begin, so no read; rd_ctrl_rdy one cycle after start.
- Reset mid-burst after 2 of 8 beats, with rd_ctrl pulsed during DATA -> outputs go to 0 immediately and no further wr_to_fifo. The ignored start causes no effect; a new start after reset runs normally.
